stopwatch_cmd_decoder: RTL
==========================

// Module: stopwatch_cmd_decoder
// PURPOSE
//  Command source for the stopwatch control unit. Decodes ASCII bytes from the UART RX into one-cycle run/stop/clear pulses.
//  Merges them with debounced button pulses and optionally acks each byte back through the UART TX.
//  Sits between uart_rx/uart_tx and the stopwatch control unit's i_run/i_stop/i_clear inputs.
// PARAMETERS
//  CHAR_RUN     8'h52  'R' -> run pulse
//  CHAR_STOP    8'h53  'S' -> stop pulse
//  CHAR_CLEAR   8'h43  'C' -> clear pulse
//  CHAR_TOGGLE  8'h54  'T' -> run if i_run_state=0, else stop
//  CASE_FOLD    1      1: lowercase a-z matched as uppercase; 0: exact match only
//  NAK_CHAR     8'h3F  '?' sent as ack for an unrecognised byte (ack build only)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-low
//  i_rx_data    in   8  received byte, valid with i_rx_done
//  i_rx_done    in   1  1-cycle strobe, byte received
//  i_btn_run    in   1  debounced 1-cycle button pulse
//  i_btn_stop   in   1  debounced 1-cycle button pulse
//  i_btn_clear  in   1  debounced 1-cycle button pulse
//  i_run_state  in   1  current run status from control unit (o_run)
//  i_tx_busy    in   1  UART TX busy
//  o_run        out  1  1-cycle run command
//  o_stop       out  1  1-cycle stop command
//  o_clear      out  1  1-cycle clear command
//  o_cmd_err    out  1  1-cycle pulse, unrecognised byte
//  o_overrun    out  1  1-cycle pulse, byte dropped
//  o_tx_start   out  1  1-cycle TX start (tied 0 without ack)
//  o_tx_data    out  8  TX byte, held from o_tx_start until next start
// BEHAVIOUR
//  - All outputs registered. Reset (rst=0 at a clk edge): every output 0, o_tx_data=8'h00, FSM=IDLE, pending buffer emptied.
//    Reset mid-operation abandons the byte in flight; no pulse or ack is emitted for it.
//  - FSM: IDLE -> DECODE -> ISSUE -> (ACK_WAIT ->) IDLE.
//  - IDLE:
//      i_rx_done at cycle N latches the byte; FSM -> DECODE.
//      If the pending buffer is valid, FSM consumes it and goes straight to DECODE.
//  - DECODE (N+1): byte classified as RUN/STOP/CLEAR/TOGGLE/ERR. TOGGLE is resolved with i_run_state sampled in this cycle.
//  - ISSUE: the output pulse is high in cycle N+2; o_cmd_err is used for ERR.
//      Exactly one of o_run/o_stop/o_clear/o_cmd_err is high per issue.
//  - Buttons: a button pulse at cycle K drives the matching output at K+1 in any state.
//      Simultaneous buttons: priority clear > stop > run; one pulse only.
//      If a button pulse and a UART issue target the same cycle, the button wins.
//      The UART command is then issued one cycle later (FSM stays in ISSUE).
//      o_run, o_stop and o_clear are therefore never high together.
//  - i_rx_done while FSM != IDLE:
//      pending buffer empty -> byte stored.
//      pending buffer full -> byte dropped and o_overrun pulses the next cycle.
//  - Case fold (CASE_FOLD=1): 8'h61..8'h7A are mapped by clearing bit 5; all other bytes are compared unmodified.
// CONFIGURATION
//  Macro STOPWATCH_CMD_ACK_EN:
//   defined:
//     ISSUE -> ACK_WAIT. ACK_WAIT waits while i_tx_busy=1.
//     On the first cycle with i_tx_busy=0: o_tx_start=1 for 1 cycle; o_tx_data = echo of the byte (valid command) or NAK_CHAR (ERR).
//     Then FSM -> IDLE.
//   undefined:
//     ISSUE -> IDLE directly; o_tx_start=0 and o_tx_data=8'h00 always.
//     i_tx_busy is ignored.
// STRUCTURE
//  - Package stopwatch_cmd_pkg: ASCII constants (R/S/C/T/?), FSM state encoding, cmd_t enum {CMD_RUN,CMD_STOP,CMD_CLEAR,CMD_TOGGLE,CMD_ERR}.
//  - Sub-module uart_cmd_classify: combinational byte + CASE_FOLD -> cmd_t. Reusable by a future TX-side status formatter.
//  - Top level holds the FSM, the 1-deep pending buffer, button arbitration and ack logic.
// TESTING
//  1. Reset: rst=0 for 3 cycles mid-command -> all outputs 0; no pulse after release.
//  2. i_rx_data=8'h52 with i_rx_done at N -> o_run=1 exactly at N+2.
//     8'h73 ('s') -> o_stop at N+2 when CASE_FOLD=1; o_cmd_err when CASE_FOLD=0.
//  3. 'T' with i_run_state=1 -> o_stop; with i_run_state=0 -> o_run.
//     8'h41 -> o_cmd_err at N+2 and no command pulse.
//  4. i_btn_clear timed so its output lands on the UART 'R' issue cycle -> o_clear at that cycle, o_run one cycle later, never both high.
//  5. Three i_rx_done strobes on consecutive cycles -> bytes 1 and 2 issued in order, byte 3 dropped with o_overrun=1.
//  6. Ack build: i_tx_busy=1 for 10 cycles after 'C' -> o_clear at N+2.
//     o_tx_start only on the first cycle with busy=0, with o_tx_data=8'h43. Byte 8'h41 -> ack byte 8'h3F.

Source files
------------

// File: rtl/stopwatch_cmd_pkg.sv
// Shared constants and types for the stopwatch command decoder.
// ASCII command characters, FSM state encoding, decoded command type
// and small helpers shared by the classifier and the top level.
package stopwatch_cmd_pkg;

  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_Q = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_ACK_WAIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CMD_RUN    = 3'd0,
    CMD_STOP   = 3'd1,
    CMD_CLEAR  = 3'd2,
    CMD_TOGGLE = 3'd3,
    CMD_ERR    = 3'd4
  } cmd_t;

  // Lowercase a-z become uppercase by clearing bit 5; everything else is untouched.
  function automatic logic [7:0] fold_upper(input logic [7:0] b);
    logic [7:0] r;
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      r = b & 8'hDF;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // Pulse vector {err, clear, stop, run} for a resolved command.
  function automatic logic [3:0] cmd_pulse(input cmd_t c);
    logic [3:0] r;
    case (c)
      CMD_RUN:   r = 4'b0001;
      CMD_STOP:  r = 4'b0010;
      CMD_CLEAR: r = 4'b0100;
      CMD_ERR:   r = 4'b1000;
      default:   r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_cmd_decoder_classify.sv
// Combinational byte classifier: received byte -> command type.
// Kept separate so a TX-side status formatter can reuse the same decode.
module uart_cmd_classify
  import stopwatch_cmd_pkg::*;
#(
  parameter bit         CASE_FOLD   = 1'b1,
  parameter logic [7:0] CHAR_RUN    = ASCII_R,
  parameter logic [7:0] CHAR_STOP   = ASCII_S,
  parameter logic [7:0] CHAR_CLEAR  = ASCII_C,
  parameter logic [7:0] CHAR_TOGGLE = ASCII_T
) (
  input  logic [7:0] data,
  output cmd_t       cmd
);

  logic [7:0] key_s;

  // Optionally fold lowercase letters onto uppercase before matching.
  always_comb begin
    if (CASE_FOLD) begin
      key_s = fold_upper(data);
    end else begin
      key_s = data;
    end
  end

  // Match the key against the configured command characters.
  always_comb begin
    cmd = CMD_ERR;
    if (key_s == CHAR_RUN) begin
      cmd = CMD_RUN;
    end else if (key_s == CHAR_STOP) begin
      cmd = CMD_STOP;
    end else if (key_s == CHAR_CLEAR) begin
      cmd = CMD_CLEAR;
    end else if (key_s == CHAR_TOGGLE) begin
      cmd = CMD_TOGGLE;
    end else begin
      cmd = CMD_ERR;
    end
  end

endmodule

// File: rtl/stopwatch_cmd_decoder.sv
// Stopwatch command decoder: turns UART bytes into one-cycle run/stop/clear
// pulses, merges debounced button pulses (buttons always win a collision),
// buffers one extra byte while busy and flags dropped bytes.
// Build option: define STOPWATCH_CMD_ACK_EN to echo each byte (or '?' for an
// unrecognised one) back through the UART TX once it is idle.
module stopwatch_cmd_decoder
  import stopwatch_cmd_pkg::*;
#(
  parameter logic [7:0] CHAR_RUN    = ASCII_R,
  parameter logic [7:0] CHAR_STOP   = ASCII_S,
  parameter logic [7:0] CHAR_CLEAR  = ASCII_C,
  parameter logic [7:0] CHAR_TOGGLE = ASCII_T,
  parameter bit         CASE_FOLD   = 1'b1,
  parameter logic [7:0] NAK_CHAR    = ASCII_Q
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_btn_run,
  input  logic       i_btn_stop,
  input  logic       i_btn_clear,
  input  logic       i_run_state,
  input  logic       i_tx_busy,
  output logic       o_run,
  output logic       o_stop,
  output logic       o_clear,
  output logic       o_cmd_err,
  output logic       o_overrun,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data
);

`ifdef STOPWATCH_CMD_ACK_EN
  localparam state_t ST_AFTER_ISSUE = ST_ACK_WAIT;
`else
  localparam state_t ST_AFTER_ISSUE = ST_IDLE;
`endif

  state_t     state_r, state_nxt_s;
  logic [7:0] byte_r, byte_nxt_s;
  logic       pend_valid_r, pend_valid_nxt_s;
  logic [7:0] pend_data_r, pend_data_nxt_s;
  cmd_t       cmd_r, cmd_nxt_s;
  logic       issued_r, issued_nxt_s;
  logic [3:0] pulse_r, pulse_nxt_s;   // {err, clear, stop, run}
  logic [3:0] btn_pulse_s, uart_pulse_s;
  logic       btn_any_s;
  logic       ovr_r, ovr_nxt_s;
  logic       tx_start_r, tx_start_nxt_s;
  logic [7:0] tx_data_r, tx_data_nxt_s;
  cmd_t       class_s, resolved_s;

  uart_cmd_classify #(
    .CASE_FOLD  (CASE_FOLD),
    .CHAR_RUN   (CHAR_RUN),
    .CHAR_STOP  (CHAR_STOP),
    .CHAR_CLEAR (CHAR_CLEAR),
    .CHAR_TOGGLE(CHAR_TOGGLE)
  ) u_classify (
    .data(byte_r),
    .cmd (class_s)
  );

  // Toggle becomes stop or run depending on the live run status.
  always_comb begin
    resolved_s = class_s;
    if (class_s == CMD_TOGGLE) begin
      resolved_s = i_run_state ? CMD_STOP : CMD_RUN;
    end else begin
      resolved_s = class_s;
    end
  end

  // Button arbitration: clear beats stop beats run, only one pulse.
  always_comb begin
    btn_pulse_s = 4'b0000;
    if (i_btn_clear) begin
      btn_pulse_s = 4'b0100;
    end else if (i_btn_stop) begin
      btn_pulse_s = 4'b0010;
    end else if (i_btn_run) begin
      btn_pulse_s = 4'b0001;
    end else begin
      btn_pulse_s = 4'b0000;
    end
  end

  assign btn_any_s   = i_btn_run | i_btn_stop | i_btn_clear;
  assign pulse_nxt_s = btn_any_s ? btn_pulse_s : uart_pulse_s;

  // Next-state logic: byte intake, pending buffer, issue deferral and ack.
  always_comb begin
    state_nxt_s      = state_r;
    byte_nxt_s       = byte_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_data_nxt_s  = pend_data_r;
    cmd_nxt_s        = cmd_r;
    issued_nxt_s     = issued_r;
    uart_pulse_s     = 4'b0000;
    ovr_nxt_s        = 1'b0;
    tx_start_nxt_s   = 1'b0;
    tx_data_nxt_s    = tx_data_r;

    if (i_rx_done && (state_r != ST_IDLE)) begin
      if (pend_valid_r) begin
        ovr_nxt_s = 1'b1;
      end else begin
        pend_valid_nxt_s = 1'b1;
        pend_data_nxt_s  = i_rx_data;
      end
    end else begin
      ovr_nxt_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (pend_valid_r) begin
          // Older buffered byte goes first; a byte arriving now refills the buffer.
          byte_nxt_s       = pend_data_r;
          pend_valid_nxt_s = i_rx_done;
          pend_data_nxt_s  = i_rx_done ? i_rx_data : pend_data_r;
          state_nxt_s      = ST_DECODE;
        end else if (i_rx_done) begin
          byte_nxt_s  = i_rx_data;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        cmd_nxt_s = resolved_s;
        if (btn_any_s) begin
          issued_nxt_s = 1'b0;
        end else begin
          uart_pulse_s = cmd_pulse(resolved_s);
          issued_nxt_s = 1'b1;
        end
        state_nxt_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issued_r) begin
          state_nxt_s = ST_AFTER_ISSUE;
        end else if (btn_any_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          uart_pulse_s = cmd_pulse(cmd_r);
          issued_nxt_s = 1'b1;
          state_nxt_s  = ST_ISSUE;
        end
      end
      ST_ACK_WAIT: begin
`ifdef STOPWATCH_CMD_ACK_EN
        if (!i_tx_busy) begin
          tx_start_nxt_s = 1'b1;
          tx_data_nxt_s  = (cmd_r == CMD_ERR) ? NAK_CHAR : byte_r;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK_WAIT;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifndef STOPWATCH_CMD_ACK_EN
  logic unused_ok_s;
  assign unused_ok_s = ^{i_tx_busy, NAK_CHAR};
`endif

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      byte_r       <= 8'h00;
      pend_valid_r <= 1'b0;
      pend_data_r  <= 8'h00;
      cmd_r        <= CMD_ERR;
      issued_r     <= 1'b0;
      pulse_r      <= 4'b0000;
      ovr_r        <= 1'b0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
    end else begin
      state_r      <= state_nxt_s;
      byte_r       <= byte_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_data_r  <= pend_data_nxt_s;
      cmd_r        <= cmd_nxt_s;
      issued_r     <= issued_nxt_s;
      pulse_r      <= pulse_nxt_s;
      ovr_r        <= ovr_nxt_s;
      tx_start_r   <= tx_start_nxt_s;
      tx_data_r    <= tx_data_nxt_s;
    end
  end

  assign o_run      = pulse_r[0];
  assign o_stop     = pulse_r[1];
  assign o_clear    = pulse_r[2];
  assign o_cmd_err  = pulse_r[3];
  assign o_overrun  = ovr_r;
  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;

endmodule
